data_memory_sb: RTL
===================

Name: data_memory_sb

Overview:
- Responder end of the memory-access-stage data memory interface.
- Accepts word loads and stores from the memory access stage and returns load data one cycle after a load is accepted.
- Holds stores in a small in-order store buffer that drains into a single-port word array whenever the array port is free.
- Loads are forwarded from the store buffer when a buffered store matches.

Parameters:
- DEPTH_L2, 10, log2 of data array depth in 32-bit words (1024 words).
- SB_DEPTH, 4, store buffer entries (power of two, 2..16).

Ports:
- clk  input  1  clock; all state updates on posedge.
- nreset  input  1  asynchronous active-low reset.
- read_en  input  1  load request this cycle.
- read_addr  input  `BIT_WIDTH  byte address of load.
- write_enable  input  1  store request this cycle.
- write_addr  input  `BIT_WIDTH  byte address of store.
- write_value  input  `BIT_WIDTH  store data.
- stall  output  1  combinational; request(s) this cycle not accepted, initiator must hold them.
- read_value  output  `BIT_WIDTH  registered load data.
- read_valid  output  1  registered; read_value holds data for the load accepted last cycle.
- sb_empty  output  1  store buffer holds no entries.

Behaviour:
- Word index = addr[DEPTH_L2+1:2]. Bits [1:0] are ignored. Bits above DEPTH_L2+1 are ignored, so addresses alias.
- Reset (async, nreset=0): SB count, head and tail = 0; read_value = 0; read_valid = 0; sb_empty = 1. Array contents are not reset. Pending SB entries are discarded. A load accepted in the cycle before reset produces no read_valid.
- Store buffer: circular FIFO of {word index, data}, oldest drained first. Entries do not coalesce; duplicate addresses are kept in order.
- Array port arbitration, one access per cycle:
  - Drain: when count>0 and (read_en=0 or count==SB_DEPTH), the oldest entry is written to the array and popped.
  - Otherwise the array port serves an accepted load.
- stall = (count==SB_DEPTH) && (read_en || write_enable).
- On a stall cycle: one entry drains; neither the load nor the store is accepted; read_valid=0 next cycle.
- Non-stall cycle:
  - A store is pushed at the tail.
  - Push and drain in the same cycle are legal; count is unchanged.
  - Count never exceeds SB_DEPTH.
- Load, accepted when read_en=1 and stall=0, has 1-cycle latency.
  - Next cycle read_valid=1 and read_value = data from the youngest valid SB entry with a matching index, or the array word if no entry matches.
  - Lookup uses SB state at the start of the cycle. A store accepted in the same cycle is NOT visible to that load; the older value is returned.
  - A store that drains in the same cycle as the lookup is still visible, via forwarding or the array.
- read_en=0 and no stall: read_valid=0 next cycle; read_value holds its last value.
- sb_empty = (count==0), driven from registered state.
- Simulation-only assertions:
  - No push when full without a simultaneous drain.
  - Count stays in 0..SB_DEPTH.
  - No read_valid on the cycle after a stall.

Test Plan:
- Reset, then read_en=1 addr 0x40 (array preloaded 0xDEADBEEF) -> cycle+1 read_valid=1, read_value=0xDEADBEEF; sb_empty=1 throughout.
- Store 0x11111111 then 0x22222222 to 0x40 on consecutive cycles, reading 0x40 every cycle after -> read_value=0x22222222 (youngest forwarded); after read_en=0 for 2 cycles, sb_empty=1 and a read returns 0x22222222 from the array.
- Same cycle: store 0x55 to 0x80 and load 0x80 (old value 0x0) -> cycle+1 read_value=0x0; a load the following cycle returns 0x55.
- 4 stores to 0x0,0x4,0x8,0xC with read_en=1 held -> count=4; 5th store plus load asserts stall=1 for one cycle, one entry drains, read_valid=0 next cycle; the retried requests are accepted the cycle after.
- Load 0x1003 with DEPTH_L2=10 -> same word as 0x0000 (alias, low bits ignored).
- Assert nreset=0 mid-operation with 3 buffered stores -> read_valid=0 and sb_empty=1 immediately (async); after release, the buffered data are not in the array.

Source files
------------

// File: rtl/data_memory_sb_if.sv
// data_memory_sb_if: load/store bus between the memory access stage and the data memory
//   master: read_en, read_addr, write_enable, write_addr, write_value out; stall, read_value, read_valid, sb_empty in
//   slave : mirror of master
interface data_memory_sb_if;
  logic        read_en;
  logic [31:0] read_addr;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [31:0] write_value;
  logic        stall;
  logic [31:0] read_value;
  logic        read_valid;
  logic        sb_empty;
  modport master(output read_en, read_addr, write_enable, write_addr, write_value,
                 input stall, read_value, read_valid, sb_empty);
  modport slave(input read_en, read_addr, write_enable, write_addr, write_value,
                output stall, read_value, read_valid, sb_empty);
endinterface

// File: rtl/data_memory_sb.sv
// data_memory_sb: word data memory with in-order store buffer and load forwarding
//   clk    : clock, all state on posedge
//   nreset : asynchronous active-low reset
//   bus    : slave side of data_memory_sb_if (load/store requests, stall, load data)
module data_memory_sb #(
  parameter int DEPTH_L2 = 10,
  parameter int SB_DEPTH = 4
) (
  input logic             clk,
  input logic             nreset,
  data_memory_sb_if.slave bus
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]         mem [2**DEPTH_L2];
  logic [DEPTH_L2-1:0] sb_idx [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [PW-1:0]       head, tail, slot;
  logic [CW-1:0]       count;
  logic [DEPTH_L2-1:0] ridx, widx;
  logic                full, drain, load, push, fwd_hit;
  logic [31:0]         fwd_data;
  logic                unused_bits;
  assign ridx  = bus.read_addr[DEPTH_L2+1:2];
  assign widx  = bus.write_addr[DEPTH_L2+1:2];
  assign unused_bits = &{1'b0, bus.read_addr[31:DEPTH_L2+2], bus.read_addr[1:0],
                         bus.write_addr[31:DEPTH_L2+2], bus.write_addr[1:0]};
  assign full  = count == CW'(SB_DEPTH);
  assign bus.stall = full && (bus.read_en || bus.write_enable);
  // the array port goes to the drain unless a load wants it; a full buffer always drains
  assign drain = count != '0 && (!bus.read_en || full);
  assign load  = bus.read_en && !bus.stall;
  assign push  = bus.write_enable && !bus.stall;
  assign bus.sb_empty = count == '0;
  // walk oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head + PW'(i);
      if (CW'(i) < count && sb_idx[slot] == ridx) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data[slot];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (drain) mem[sb_idx[head]] <= sb_data[head];
    if (push) begin
      sb_idx[tail]  <= widx;
      sb_data[tail] <= bus.write_value;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      bus.read_value <= '0;
      bus.read_valid <= 1'b0;
    end else begin
      head           <= drain ? head + 1'b1 : head;
      tail           <= push ? tail + 1'b1 : tail;
      count          <= count + CW'(push) - CW'(drain);
      bus.read_valid <= load;
      if (load) bus.read_value <= fwd_hit ? fwd_data : mem[ridx];
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!nreset) !(push && full && !drain));
  a_count_range: assert property (@(posedge clk) disable iff (!nreset) count <= CW'(SB_DEPTH));
  a_stall_no_valid: assert property (@(posedge clk) disable iff (!nreset) bus.stall |=> !bus.read_valid);
endmodule
